issue_reg_exe0: RTL and testbench
=================================

# issue_reg_exe0

Dual-issue issue stage and reg→exe0 pipeline register. Accepts a decoded, register-read instruction pair from the reg stage and detects load-use and intra-pair dependences. Launches each pair into exe0 as a full pair, a split (slot0 then slot1), or a bubble. Its registered outputs are the `*_reg_exe0_*` operands and indices consumed by the exe0 forwarding unit.

## Interface
Parameters:
- CTR_WE_BIT, 6: control-word bit meaning "writes rd".
- CTR_LD_BIT, 12: control-word bit meaning "load; result valid only after exe1".

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: clock.
  - rstn, in, 1: asynchronous active-low reset.
- Control:
  - flush, in, 1: squash; has priority over everything else.
  - stall_exe, in, 1: exe0 cannot advance; hold outputs.
- Reg-stage pair:
  - valid_reg_0, valid_reg_1, in, 1 each: reg-stage slot valid.
  - ready_reg, out, 1: the pair is fully consumed this cycle.
  - pc_reg_0/1, in, 32 each.
  - ctr_reg_0/1, in, 32 each.
  - rj_reg_0/1, rk_reg_0/1, rd_reg_0/1, in, 5 each.
  - rrj_reg_0/1, rrk_reg_0/1, rrd_reg_0/1, in, 32 each: register-file read values.
- Hazard inputs:
  - ctr_exe0_exe1_0/1, in, 32 each.
  - rd_exe0_exe1_0/1, in, 5 each: instructions currently in exe1.
- Outputs to exe0:
  - valid_exe0_0/1, out, 1 each.
  - pc_reg_exe0_0/1, ctr_reg_exe0_0/1, out, 32 each.
  - rj0/rj1, rk0/rk1, rd0/rd1, out, 5 each.
  - rrj_reg_exe0_0/1, rrk_reg_exe0_0/1, rrd_reg_exe0_0/1, out, 32 each.

## Operation
- Lane 1 is always the younger instruction. Slot i of a pair only ever issues into lane i.
- Producer "load" = ctr[CTR_LD_BIT] & ctr[CTR_WE_BIT] & (rd != 0).
- A consumer conflicts with a producer when any nonzero rj/rk/rd of the consumer equals the producer's rd. rd is counted as a source because stores and branches read it.
- Load-use hazard for slot i:
  - A conflict with a valid lane of this block's own output register that is a load (it moves to exe1 this cycle), or
  - A conflict with an exe0_exe1 lane that is a load.
- Intra-pair dependence: ctr_reg_0[CTR_WE_BIT] & (rd_reg_0 != 0), and rd_reg_0 equals a nonzero rj/rk/rd of slot1.
- States:
  - PAIR: nothing from the current pair has issued.
  - HALF: slot0 has issued and slot1 is pending.
- In PAIR, with valid_reg_0 set:
  - Slot0 load-use → bubble; ready_reg=0; stay in PAIR.
  - Otherwise, valid_reg_1=0 → issue slot0 alone; ready_reg=1.
  - Otherwise, slot1 intra-dependent or slot1 load-use → issue slot0 in lane0 with lane1 bubble; ready_reg=0; go to HALF.
  - Otherwise → issue both; ready_reg=1.
- In HALF:
  - Slot1 load-use (slot0 is now in the output register) → bubble; stay in HALF.
  - Otherwise → issue slot1 in lane1 with lane0 bubble; ready_reg=1; go to PAIR.
- No valid input → bubble; ready_reg=1.
- Bubble lane: valid=0, ctr=0 (bit CTR_WE_BIT clear, so nothing is forwarded from it), all other fields 0.
- Upstream holds the pair stable while ready_reg=0 and re-reads the register file every cycle. The register file is write-first for wb writes, so operands taken in HALF or after a stall are current.
- stall_exe=1: hold every output register and the state; ready_reg=0.
- flush=1: both output lanes become bubbles; state → PAIR; ready_reg=1 (the upstream pair is discarded). Flush overrides stall_exe.

## Timing
- Registered outputs, 1-cycle latency from acceptance to the exe0 outputs. ready_reg is combinational from inputs and state.
- Reset (rstn low, asynchronous): state=PAIR; all outputs 0, including valid_exe0_*=0 and ctr_reg_exe0_*=0.
- A load immediately followed by a dependent instruction gets 2 bubbles: one while the load is in exe0, one while it is in exe1. The consumer enters exe0 when the load is in wb and is fed by forwarding from exe1_wb.
- A dependent pair in which neither instruction is a load costs 1 extra cycle (the split).
- Reset deasserted mid-split: resumes in PAIR. The upstream re-presents the whole pair.

## Structure
- Shared package `issue_pkg`: CTR_WE_BIT and CTR_LD_BIT defaults, the PAIR/HALF state enum.
- Sub-module `load_use_check`: one consumer (rj, rk, rd) against four producers (ctr, rd). Instantiated twice, once per slot.

## Test plan
1. Independent pair: add r4 and sub r5 with disjoint sources → both lanes valid next cycle; ready_reg=1; no bubble.
2. Intra-dependent pair: slot0 writes r4, slot1 reads rj=r4 → cycle 1: lane0 valid, lane1 bubble. Cycle 2: lane1 valid with lane0 bubble; ready_reg=1 only in cycle 2.
3. Load-use: a load writing r7 is issued, and the next pair's slot0 reads rk=r7 → two bubble cycles, then issue. ctr_reg_exe0_*=0 during the bubbles.
4. A load writing r0 followed by a reader of r0 → no stall.
5. stall_exe held for 3 cycles mid-HALF → outputs and state frozen; slot1 issues the cycle after release.
6. flush asserted together with stall_exe while in HALF → next cycle both lanes are bubbles, state=PAIR, ready_reg=1. Async reset mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/issue_reg_exe0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_pkg
// Description : Shared types and helpers for the reg->exe0 issue stage:
//               control-word bit defaults, issue state enum, lane record and
//               the register-conflict helper.
// Revision    : 1.0  initial release
// ============================================================================
package issue_pkg;

  localparam int unsigned CTR_WE_BIT_DEF = 6;
  localparam int unsigned CTR_LD_BIT_DEF = 12;

  // PAIR: nothing of the current pair issued; HALF: slot0 issued, slot1 pending
  typedef enum logic [0:0] {
    ST_PAIR = 1'b0,
    ST_HALF = 1'b1
  } issue_state_e;

  // One pipeline lane as held in the reg->exe0 register
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ctr;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic [4:0]  rd;
    logic [31:0] rrj;
    logic [31:0] rrk;
    logic [31:0] rrd;
  } lane_t;

  // True when a nonzero producer rd matches any of the consumer's rj/rk/rd.
  // rd counts as a source since stores and branches read it.
  function automatic logic reads_reg(input logic [4:0] rj, input logic [4:0] rk,
                                     input logic [4:0] rd, input logic [4:0] prd);
    return (prd != 5'd0) && ((rj == prd) || (rk == prd) || (rd == prd));
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_reg_exe0_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_reg_exe0_if
// Description : Bundle of control, reg-stage pair, hazard and exe0 output
//               signals of the issue stage. master = surrounding pipeline,
//               slave = issue stage.
// Revision    : 1.0  initial release
// ============================================================================
interface issue_reg_exe0_if;

  logic        flush;
  logic        stall_exe;

  logic        valid_reg_0, valid_reg_1;
  logic        ready_reg;
  logic [31:0] pc_reg_0, pc_reg_1;
  logic [31:0] ctr_reg_0, ctr_reg_1;
  logic [4:0]  rj_reg_0, rj_reg_1, rk_reg_0, rk_reg_1, rd_reg_0, rd_reg_1;
  logic [31:0] rrj_reg_0, rrj_reg_1, rrk_reg_0, rrk_reg_1, rrd_reg_0, rrd_reg_1;

  logic [31:0] ctr_exe0_exe1_0, ctr_exe0_exe1_1;
  logic [4:0]  rd_exe0_exe1_0, rd_exe0_exe1_1;

  logic        valid_exe0_0, valid_exe0_1;
  logic [31:0] pc_reg_exe0_0, pc_reg_exe0_1;
  logic [31:0] ctr_reg_exe0_0, ctr_reg_exe0_1;
  logic [4:0]  rj0, rj1, rk0, rk1, rd0, rd1;
  logic [31:0] rrj_reg_exe0_0, rrj_reg_exe0_1;
  logic [31:0] rrk_reg_exe0_0, rrk_reg_exe0_1;
  logic [31:0] rrd_reg_exe0_0, rrd_reg_exe0_1;

  modport master (
    output flush, stall_exe,
    output valid_reg_0, valid_reg_1, pc_reg_0, pc_reg_1, ctr_reg_0, ctr_reg_1,
    output rj_reg_0, rj_reg_1, rk_reg_0, rk_reg_1, rd_reg_0, rd_reg_1,
    output rrj_reg_0, rrj_reg_1, rrk_reg_0, rrk_reg_1, rrd_reg_0, rrd_reg_1,
    output ctr_exe0_exe1_0, ctr_exe0_exe1_1, rd_exe0_exe1_0, rd_exe0_exe1_1,
    input  ready_reg,
    input  valid_exe0_0, valid_exe0_1, pc_reg_exe0_0, pc_reg_exe0_1,
    input  ctr_reg_exe0_0, ctr_reg_exe0_1, rj0, rj1, rk0, rk1, rd0, rd1,
    input  rrj_reg_exe0_0, rrj_reg_exe0_1, rrk_reg_exe0_0, rrk_reg_exe0_1,
    input  rrd_reg_exe0_0, rrd_reg_exe0_1
  );

  modport slave (
    input  flush, stall_exe,
    input  valid_reg_0, valid_reg_1, pc_reg_0, pc_reg_1, ctr_reg_0, ctr_reg_1,
    input  rj_reg_0, rj_reg_1, rk_reg_0, rk_reg_1, rd_reg_0, rd_reg_1,
    input  rrj_reg_0, rrj_reg_1, rrk_reg_0, rrk_reg_1, rrd_reg_0, rrd_reg_1,
    input  ctr_exe0_exe1_0, ctr_exe0_exe1_1, rd_exe0_exe1_0, rd_exe0_exe1_1,
    output ready_reg,
    output valid_exe0_0, valid_exe0_1, pc_reg_exe0_0, pc_reg_exe0_1,
    output ctr_reg_exe0_0, ctr_reg_exe0_1, rj0, rj1, rk0, rk1, rd0, rd1,
    output rrj_reg_exe0_0, rrj_reg_exe0_1, rrk_reg_exe0_0, rrk_reg_exe0_1,
    output rrd_reg_exe0_0, rrd_reg_exe0_1
  );

endinterface
`default_nettype wire

// File: rtl/issue_reg_exe0_load_use_check.sv
`default_nettype none
// ============================================================================
// Module      : load_use_check
// Description : One consumer (rj, rk, rd) against four producers. Flags a
//               hazard when a producer is a load writing a nonzero rd that
//               the consumer reads.
// Revision    : 1.0  initial release
// ============================================================================
module load_use_check
  import issue_pkg::*;
(
  input  logic [4:0]      rj_i,
  input  logic [4:0]      rk_i,
  input  logic [4:0]      rd_i,
  input  logic [3:0]      prod_we_i,   // producer ctr[CTR_WE_BIT]
  input  logic [3:0]      prod_ld_i,   // producer ctr[CTR_LD_BIT]
  input  logic [3:0][4:0] prod_rd_i,
  output logic            hazard_o
);

  logic [3:0] hit;

  // Per-producer match; reads_reg already excludes rd == 0
  for (genvar g = 0; g < 4; g++) begin : g_prod
    assign hit[g] = prod_ld_i[g] & prod_we_i[g] &
                    reads_reg(rj_i, rk_i, rd_i, prod_rd_i[g]);
  end

  assign hazard_o = |hit;

endmodule
`default_nettype wire

// File: rtl/issue_reg_exe0.sv
`default_nettype none
// ============================================================================
// Module      : issue_reg_exe0
// Description : Dual-issue issue stage and reg->exe0 pipeline register.
//               Issues a pair whole, split (slot0 then slot1) or as a bubble
//               depending on load-use and intra-pair dependences.
// Revision    : 1.0  initial release
// ============================================================================
module issue_reg_exe0
  import issue_pkg::*;
#(
  parameter int unsigned CTR_WE_BIT = CTR_WE_BIT_DEF,
  parameter int unsigned CTR_LD_BIT = CTR_LD_BIT_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  issue_reg_exe0_if.slave  bus
);

  lane_t        slot0, slot1;
  lane_t        lane0_q, lane1_q, lane0_d, lane1_d;
  issue_state_e state_q, state_d;
  logic         ready_d;
  logic         luse0, luse1, intra;

  logic [3:0]      prod_we, prod_ld;
  logic [3:0][4:0] prod_rd;

  assign slot0 = '{valid: bus.valid_reg_0, pc: bus.pc_reg_0, ctr: bus.ctr_reg_0,
                   rj: bus.rj_reg_0, rk: bus.rk_reg_0, rd: bus.rd_reg_0,
                   rrj: bus.rrj_reg_0, rrk: bus.rrk_reg_0, rrd: bus.rrd_reg_0};
  assign slot1 = '{valid: bus.valid_reg_1, pc: bus.pc_reg_1, ctr: bus.ctr_reg_1,
                   rj: bus.rj_reg_1, rk: bus.rk_reg_1, rd: bus.rd_reg_1,
                   rrj: bus.rrj_reg_1, rrk: bus.rrk_reg_1, rrd: bus.rrd_reg_1};

  // Producers: own output lanes (moving to exe1 now) and the exe1 lanes.
  // Bubble lanes carry ctr=0, so they never look like loads.
  assign prod_we = {bus.ctr_exe0_exe1_1[CTR_WE_BIT], bus.ctr_exe0_exe1_0[CTR_WE_BIT],
                    lane1_q.ctr[CTR_WE_BIT], lane0_q.ctr[CTR_WE_BIT]};
  assign prod_ld = {bus.ctr_exe0_exe1_1[CTR_LD_BIT], bus.ctr_exe0_exe1_0[CTR_LD_BIT],
                    lane1_q.ctr[CTR_LD_BIT], lane0_q.ctr[CTR_LD_BIT]};
  assign prod_rd = {bus.rd_exe0_exe1_1, bus.rd_exe0_exe1_0, lane1_q.rd, lane0_q.rd};

  load_use_check u_luc0 (
    .rj_i(slot0.rj), .rk_i(slot0.rk), .rd_i(slot0.rd),
    .prod_we_i(prod_we), .prod_ld_i(prod_ld), .prod_rd_i(prod_rd),
    .hazard_o(luse0)
  );

  load_use_check u_luc1 (
    .rj_i(slot1.rj), .rk_i(slot1.rk), .rd_i(slot1.rd),
    .prod_we_i(prod_we), .prod_ld_i(prod_ld), .prod_rd_i(prod_rd),
    .hazard_o(luse1)
  );

  // Slot1 reads what slot0 writes: must split the pair
  assign intra = slot0.ctr[CTR_WE_BIT] &
                 reads_reg(slot1.rj, slot1.rk, slot1.rd, slot0.rd);

  // Issue decision: next lane contents, next state and upstream ready.
  // A pair with valid_reg_0 clear is treated as empty.
  always_comb begin
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    state_d = state_q;
    ready_d = 1'b0;
    if (bus.flush) begin
      lane0_d = '0;
      lane1_d = '0;
      state_d = ST_PAIR;
      ready_d = 1'b1;
    end else if (!bus.stall_exe) begin
      lane0_d = '0;
      lane1_d = '0;
      case (state_q)
        ST_PAIR: begin
          if (!slot0.valid) begin
            ready_d = 1'b1;
          end else if (luse0) begin
            ready_d = 1'b0;
          end else if (!slot1.valid) begin
            lane0_d = slot0;
            ready_d = 1'b1;
          end else if (intra || luse1) begin
            lane0_d = slot0;
            state_d = ST_HALF;
          end else begin
            lane0_d = slot0;
            lane1_d = slot1;
            ready_d = 1'b1;
          end
        end
        ST_HALF: begin
          if (!luse1) begin
            lane1_d = slot1;
            ready_d = 1'b1;
            state_d = ST_PAIR;
          end
        end
        default: state_d = ST_PAIR;
      endcase
    end
  end

  // Output lane registers and issue state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_PAIR;
      lane0_q <= '0;
      lane1_q <= '0;
    end else begin
      state_q <= state_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
    end
  end

  assign bus.ready_reg      = ready_d;
  assign bus.valid_exe0_0   = lane0_q.valid;
  assign bus.valid_exe0_1   = lane1_q.valid;
  assign bus.pc_reg_exe0_0  = lane0_q.pc;
  assign bus.pc_reg_exe0_1  = lane1_q.pc;
  assign bus.ctr_reg_exe0_0 = lane0_q.ctr;
  assign bus.ctr_reg_exe0_1 = lane1_q.ctr;
  assign bus.rj0            = lane0_q.rj;
  assign bus.rj1            = lane1_q.rj;
  assign bus.rk0            = lane0_q.rk;
  assign bus.rk1            = lane1_q.rk;
  assign bus.rd0            = lane0_q.rd;
  assign bus.rd1            = lane1_q.rd;
  assign bus.rrj_reg_exe0_0 = lane0_q.rrj;
  assign bus.rrj_reg_exe0_1 = lane1_q.rrj;
  assign bus.rrk_reg_exe0_0 = lane0_q.rrk;
  assign bus.rrk_reg_exe0_1 = lane1_q.rrk;
  assign bus.rrd_reg_exe0_0 = lane0_q.rrd;
  assign bus.rrd_reg_exe0_1 = lane1_q.rrd;

endmodule
`default_nettype wire

// File: tb/tb_issue_reg_exe0.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_reg_exe0
// Description : Directed self-checking bench for issue_reg_exe0.
// Revision    : 1.0  initial release
// ============================================================================
module tb_issue_reg_exe0;

  localparam logic [31:0] C_ALU   = 32'h0000_0041;  // writes rd
  localparam logic [31:0] C_LOAD  = 32'h0000_1041;  // load, writes rd
  localparam logic [31:0] C_STORE = 32'h0000_0002;  // no rd write

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  issue_reg_exe0_if bus ();

  issue_reg_exe0 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] pc, input logic [31:0] ctr,
                      input logic [4:0] rj, input logic [4:0] rk, input logic [4:0] rd);
    bus.valid_reg_0 = v;   bus.pc_reg_0 = pc;  bus.ctr_reg_0 = ctr;
    bus.rj_reg_0 = rj;     bus.rk_reg_0 = rk;  bus.rd_reg_0 = rd;
    bus.rrj_reg_0 = 32'hA000_0000 | pc;
    bus.rrk_reg_0 = 32'hB000_0000 | pc;
    bus.rrd_reg_0 = 32'hC000_0000 | pc;
  endtask

  task automatic set1(input logic v, input logic [31:0] pc, input logic [31:0] ctr,
                      input logic [4:0] rj, input logic [4:0] rk, input logic [4:0] rd);
    bus.valid_reg_1 = v;   bus.pc_reg_1 = pc;  bus.ctr_reg_1 = ctr;
    bus.rj_reg_1 = rj;     bus.rk_reg_1 = rk;  bus.rd_reg_1 = rd;
    bus.rrj_reg_1 = 32'hA000_0000 | pc;
    bus.rrk_reg_1 = 32'hB000_0000 | pc;
    bus.rrd_reg_1 = 32'hC000_0000 | pc;
  endtask

  task automatic set_exe1(input logic [31:0] c0, input logic [4:0] r0,
                          input logic [31:0] c1, input logic [4:0] r1);
    bus.ctr_exe0_exe1_0 = c0; bus.rd_exe0_exe1_0 = r0;
    bus.ctr_exe0_exe1_1 = c1; bus.rd_exe0_exe1_1 = r1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    bus.flush = 1'b0;
    bus.stall_exe = 1'b0;
    set0(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    set1(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    set_exe1(32'h0, 5'd0, 32'h0, 5'd0);

    // Reset state
    #12;
    chk("rst_valid0", {31'b0, bus.valid_exe0_0}, 32'h0);
    chk("rst_valid1", {31'b0, bus.valid_exe0_1}, 32'h0);
    chk("rst_ctr0", bus.ctr_reg_exe0_0, 32'h0);
    chk("rst_ctr1", bus.ctr_reg_exe0_1, 32'h0);
    chk("rst_rrj0", bus.rrj_reg_exe0_0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // 1: independent pair issues whole
    set0(1'b1, 32'h100, C_ALU, 5'd1, 5'd2, 5'd4);
    set1(1'b1, 32'h104, C_ALU, 5'd3, 5'd6, 5'd5);
    #1;
    chk("t1_ready", {31'b0, bus.ready_reg}, 32'h1);
    tick();
    chk("t1_valid0", {31'b0, bus.valid_exe0_0}, 32'h1);
    chk("t1_valid1", {31'b0, bus.valid_exe0_1}, 32'h1);
    chk("t1_pc0", bus.pc_reg_exe0_0, 32'h100);
    chk("t1_pc1", bus.pc_reg_exe0_1, 32'h104);
    chk("t1_rd1", {27'b0, bus.rd1}, 32'd5);
    chk("t1_rrj0", bus.rrj_reg_exe0_0, 32'hA000_0100);
    chk("t1_rrd1", bus.rrd_reg_exe0_1, 32'hC000_0104);

    // 2: intra-dependent pair splits
    set0(1'b1, 32'h200, C_ALU, 5'd1, 5'd2, 5'd4);
    set1(1'b1, 32'h204, C_ALU, 5'd4, 5'd3, 5'd8);
    #1;
    chk("t2_ready_c1", {31'b0, bus.ready_reg}, 32'h0);
    tick();
    chk("t2_c1_valid0", {31'b0, bus.valid_exe0_0}, 32'h1);
    chk("t2_c1_pc0", bus.pc_reg_exe0_0, 32'h200);
    chk("t2_c1_valid1", {31'b0, bus.valid_exe0_1}, 32'h0);
    chk("t2_c1_ctr1", bus.ctr_reg_exe0_1, 32'h0);
    chk("t2_ready_c2", {31'b0, bus.ready_reg}, 32'h1);
    tick();
    chk("t2_c2_valid0", {31'b0, bus.valid_exe0_0}, 32'h0);
    chk("t2_c2_ctr0", bus.ctr_reg_exe0_0, 32'h0);
    chk("t2_c2_valid1", {31'b0, bus.valid_exe0_1}, 32'h1);
    chk("t2_c2_pc1", bus.pc_reg_exe0_1, 32'h204);
    chk("t2_c2_rj1", {27'b0, bus.rj1}, 32'd4);

    // 3: load r7, then a consumer of r7 gets two bubbles
    set0(1'b1, 32'h300, C_LOAD, 5'd1, 5'd0, 5'd7);
    set1(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("t3_ld_ready", {31'b0, bus.ready_reg}, 32'h1);
    tick();
    chk("t3_ld_ctr0", bus.ctr_reg_exe0_0, C_LOAD);
    chk("t3_ld_valid1", {31'b0, bus.valid_exe0_1}, 32'h0);
    set0(1'b1, 32'h304, C_ALU, 5'd2, 5'd7, 5'd9);
    #1;
    chk("t3_b1_ready", {31'b0, bus.ready_reg}, 32'h0);
    tick();
    chk("t3_b1_valid0", {31'b0, bus.valid_exe0_0}, 32'h0);
    chk("t3_b1_ctr0", bus.ctr_reg_exe0_0, 32'h0);
    chk("t3_b1_ctr1", bus.ctr_reg_exe0_1, 32'h0);
    set_exe1(C_LOAD, 5'd7, 32'h0, 5'd0);
    #1;
    chk("t3_b2_ready", {31'b0, bus.ready_reg}, 32'h0);
    tick();
    chk("t3_b2_valid0", {31'b0, bus.valid_exe0_0}, 32'h0);
    chk("t3_b2_ctr0", bus.ctr_reg_exe0_0, 32'h0);
    set_exe1(32'h0, 5'd0, 32'h0, 5'd0);
    #1;
    chk("t3_go_ready", {31'b0, bus.ready_reg}, 32'h1);
    tick();
    chk("t3_go_valid0", {31'b0, bus.valid_exe0_0}, 32'h1);
    chk("t3_go_pc0", bus.pc_reg_exe0_0, 32'h304);

    // 4: load to r0 never stalls a reader
    set0(1'b1, 32'h400, C_LOAD, 5'd1, 5'd0, 5'd0);
    tick();
    set0(1'b1, 32'h404, C_ALU, 5'd0, 5'd0, 5'd3);
    set_exe1(C_LOAD, 5'd0, 32'h0, 5'd0);
    #1;
    chk("t4_ready", {31'b0, bus.ready_reg}, 32'h1);
    tick();
    chk("t4_valid0", {31'b0, bus.valid_exe0_0}, 32'h1);
    chk("t4_pc0", bus.pc_reg_exe0_0, 32'h404);
    set_exe1(32'h0, 5'd0, 32'h0, 5'd0);

    // 5: split via a store reading rd, then a 3-cycle stall in HALF
    set0(1'b1, 32'h500, C_ALU, 5'd1, 5'd2, 5'd10);
    set1(1'b1, 32'h504, C_STORE, 5'd2, 5'd3, 5'd10);
    #1;
    chk("t5_ready_pair", {31'b0, bus.ready_reg}, 32'h0);
    tick();
    chk("t5_half_pc0", bus.pc_reg_exe0_0, 32'h500);
    bus.stall_exe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_stall_ready", {31'b0, bus.ready_reg}, 32'h0);
      tick();
      chk("t5_stall_valid0", {31'b0, bus.valid_exe0_0}, 32'h1);
      chk("t5_stall_pc0", bus.pc_reg_exe0_0, 32'h500);
      chk("t5_stall_valid1", {31'b0, bus.valid_exe0_1}, 32'h0);
    end
    bus.stall_exe = 1'b0;
    #1;
    chk("t5_rel_ready", {31'b0, bus.ready_reg}, 32'h1);
    tick();
    chk("t5_rel_valid0", {31'b0, bus.valid_exe0_0}, 32'h0);
    chk("t5_rel_valid1", {31'b0, bus.valid_exe0_1}, 32'h1);
    chk("t5_rel_pc1", bus.pc_reg_exe0_1, 32'h504);
    chk("t5_rel_ctr1", bus.ctr_reg_exe0_1, C_STORE);

    // 6: flush with stall while in HALF
    set0(1'b1, 32'h600, C_ALU, 5'd1, 5'd2, 5'd11);
    set1(1'b1, 32'h604, C_ALU, 5'd11, 5'd2, 5'd12);
    tick();
    chk("t6_half_pc0", bus.pc_reg_exe0_0, 32'h600);
    bus.flush = 1'b1;
    bus.stall_exe = 1'b1;
    #1;
    chk("t6_flush_ready", {31'b0, bus.ready_reg}, 32'h1);
    tick();
    bus.flush = 1'b0;
    bus.stall_exe = 1'b0;
    chk("t6_fl_valid0", {31'b0, bus.valid_exe0_0}, 32'h0);
    chk("t6_fl_valid1", {31'b0, bus.valid_exe0_1}, 32'h0);
    chk("t6_fl_ctr0", bus.ctr_reg_exe0_0, 32'h0);
    chk("t6_fl_ctr1", bus.ctr_reg_exe0_1, 32'h0);
    #1;
    chk("t6_state_pair", {31'b0, bus.ready_reg}, 32'h0);
    tick();
    chk("t6_again_pc0", bus.pc_reg_exe0_0, 32'h600);

    // Async reset mid-cycle and mid-split
    #3;
    rstn = 1'b0;
    #1;
    chk("t6_arst_valid0", {31'b0, bus.valid_exe0_0}, 32'h0);
    chk("t6_arst_pc0", bus.pc_reg_exe0_0, 32'h0);
    chk("t6_arst_ctr0", bus.ctr_reg_exe0_0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("t6_arst_pair", {31'b0, bus.ready_reg}, 32'h0);
    tick();
    chk("t6_resume_pc0", bus.pc_reg_exe0_0, 32'h600);
    chk("t6_resume_valid1", {31'b0, bus.valid_exe0_1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
